// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one booth32 multiplier between two requesters.
// Operands are latched at grant; the product is captured after SETTLE cycles.
module mul_sched #(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [63:0] result,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] res_q, res_d;
   logic        last_q, last_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        pick1;

   // last_q high means requester 1 was granted last, so 0 wins the next tie
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         res_q   <= 64'd0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         last_q  <= last_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      pick1   = req1 & (~req0 | ~last_q);
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = RUN;
               cnt_d   = CNT_INIT;
               last_d  = pick1;
               a_d     = pick1 ? a1 : a0;
               b_d     = pick1 ? b1 : b0;
               gnt0_d  = ~pick1;
               gnt1_d  = pick1;
            end
         end
         RUN: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               res_d   = mul_p;
               done0_d = ~last_q;
               done1_d = last_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      mul_a  = a_q;
      mul_b  = b_q;
      result = res_q;
      gnt0   = gnt0_q;
      gnt1   = gnt1_q;
      done0  = done0_q;
      done1  = done1_q;
   end

endmodule
